i2s_clkgen: RTL and testbench
=============================

Name: i2s_clkgen

Overview:
Master-mode I2S timing generator that sits directly upstream of the I2S core. It drives the bit clock (SCK), the word-select (WS) and a one-cycle SCK-rise strobe (sck_trg) from the system clock. The core uses these to register WS and shift TX/RX data. Divider, channel length and format are programmable and take effect only on frame boundaries.

Parameters:
DIV_WIDTH, 16, width of the SCK half-period divider input.

Ports:
clk_i  input  1  system clock; every flop is clocked on its rising edge
rst_i  input  1  reset; synchronous and active-high
en_i  input  1  run request; level-sensitive
div_i  input  DIV_WIDTH  SCK half-period minus one, in clk_i cycles
chl_i  input  2  channel length: I2S_DAT_8/16/24/32_BITS gives N = 8/16/24/32
fmt_i  input  2  2'b00 = Philips I2S (WS one bit early); any other value = left-justified
busy_o  output  1  high while the generator is running (not IDLE)
frame_o  output  1  one-cycle pulse on the SCK fall that starts bit position 0
i2s_sck_o  output  1  bit clock
i2s_sck_trg_o  output  1  one-cycle pulse in the clk_i cycle in which i2s_sck_o rises
i2s_ws_o  output  1  word select: 0 = left channel, 1 = right channel

Behaviour:
- Reset (rst_i=1 at a clk_i edge): every output 0, FSM enters IDLE, counters cleared. Reset mid-frame aborts immediately, with no graceful finish.
- FSM states: IDLE and RUN.
- IDLE -> RUN when en_i=1. In the same edge:
  - load shadow copies of div_i, chl_i and fmt_i;
  - div_cnt = 0, sck = 0;
  - bit position p = 2N-1;
  - WS = ws(2N-1), which is 1 for left-justified and 0 for I2S.
- Divider:
  - div_cnt increments each cycle in RUN.
  - When div_cnt == div_sh, div_cnt wraps to 0 and SCK toggles.
  - Half-period is div_sh+1 cycles, so div=0 gives SCK = clk_i/2.
- On each SCK rise: i2s_sck_trg_o=1 for exactly one cycle, aligned with i2s_sck_o changing 0->1.
- On each SCK fall, p increments modulo 2N, and WS is updated in the same cycle from the new p:
  - left-justified: ws = 1 iff p in [N, 2N-1];
  - I2S: ws = 1 iff p in [N-1, 2N-2].
  - WS never changes except coincident with a SCK fall.
- Frame boundary is a fall with p wrapping 2N-1 -> 0:
  - frame_o pulses for one cycle;
  - if en_i=1, reload the div/chl/fmt shadows (new settings apply from p=0);
  - if en_i=0, go to IDLE instead of falling into p=0. SCK stays 0, WS is forced to 0, busy_o=0 and frame_o is not asserted.
- en_i deassertion mid-frame is ignored until the frame boundary, so frames are never truncated.
- Changes to div_i, chl_i or fmt_i mid-frame have no effect until the next boundary.
- Steady-state latency: first SCK rise 1+div cycles after the IDLE->RUN edge; first frame_o at 2*(div+1) cycles.
- busy_o = (state == RUN).

Decomposition:
- Shared package gets:
  - I2S_FMT_I2S / I2S_FMT_LJ encodings;
  - I2S_CLKGEN_IDLE / I2S_CLKGEN_RUN state constants;
  - a chl-to-N lookup function, reusing the existing I2S_DAT_* encodings.
- One natural sub-module, i2s_sck_div: a loadable half-period counter with toggle output and rise/fall strobes.
- The FSM and the bit/WS logic stay in i2s_clkgen.

Test Plan:
- Reset and idle: rst_i=1 for 3 cycles, then en_i=0 for 20 cycles -> all outputs stay 0.
- Basic left-justified, div=1, chl=8 bit, fmt=LJ:
  - en_i=1 -> SCK period 4 clk, frame_o every 64 clk;
  - WS=0 for fall indices p 0..7 and 1 for p 8..15;
  - exactly 16 sck_trg pulses per frame.
- Philips I2S, div=0, chl=16 bit, fmt=I2S:
  - SCK period 2 clk;
  - WS rises on the fall that makes p=15 and falls on the fall that makes p=31.
- Frame-boundary reconfiguration: with div=3 and chl=8 running, write div=0 and chl=32 at p=5 -> the rest of the frame stays at period 8 clk with 16 bits; the next frame has period 2 clk and 64 bits.
- Graceful stop: drop en_i at p=3 of a 16-bit frame -> SCK keeps toggling until the p=31 -> 0 fall, then sck=0, ws=0, busy_o=0 and no frame_o on that edge.
- Reset mid-frame: assert rst_i at p=10 -> the next cycle has all outputs 0. After release with en_i=1, timing restarts from p=2N-1 as on a fresh start.

Source files
------------

// File: rtl/i2s_clkgen_pkg.sv
// Shared encodings and helpers for the I2S master timing generator.
// Channel-length codes match the I2S core's I2S_DAT_* register field.
package i2s_clkgen_pkg;

  localparam logic [1:0] I2S_DAT_8_BITS  = 2'b00;
  localparam logic [1:0] I2S_DAT_16_BITS = 2'b01;
  localparam logic [1:0] I2S_DAT_24_BITS = 2'b10;
  localparam logic [1:0] I2S_DAT_32_BITS = 2'b11;

  localparam logic [1:0] I2S_FMT_I2S = 2'b00;
  localparam logic [1:0] I2S_FMT_LJ  = 2'b01;

  typedef enum logic {
    I2S_CLKGEN_IDLE = 1'b0,
    I2S_CLKGEN_RUN  = 1'b1
  } i2s_clkgen_state_t;

  function automatic logic [5:0] chl_to_n(input logic [1:0] chl);
    case (chl)
      I2S_DAT_8_BITS:  return 6'd8;
      I2S_DAT_16_BITS: return 6'd16;
      I2S_DAT_24_BITS: return 6'd24;
      default:         return 6'd32;
    endcase
  endfunction

  // Highest bit position of a frame, 2N-1 (at most 63).
  function automatic logic [5:0] last_bit(input logic [5:0] n);
    logic [6:0] t;
    t = {n, 1'b0} - 7'd1;
    return t[5:0];
  endfunction

  // Philips I2S leads the word select by one bit; any other format is left-justified.
  function automatic logic ws_for_bit(input logic [5:0] p, input logic [5:0] n,
                                      input logic [1:0] fmt);
    logic [6:0] pw;
    logic [6:0] nw;
    pw = {1'b0, p};
    nw = {1'b0, n};
    if (fmt == I2S_FMT_I2S)
      return (pw >= nw - 7'd1) && (pw <= {n, 1'b0} - 7'd2);
    else
      return pw >= nw;
  endfunction

endpackage

// File: rtl/i2s_sck_div.sv
// SCK half-period divider: counts to div, toggles sck on wrap, and flags the edges.
// rise is registered alongside sck; fall is the combinational "sck falls this edge" tick.
module i2s_sck_div #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 sck,
  output logic                 rise,
  output logic                 fall
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic                 wrap;

  assign wrap = run && (cnt_q == div);
  assign fall = wrap && sck;

  // Holding the counter cleared while stopped makes every start phase-aligned.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_q <= '0;
      sck   <= 1'b0;
      rise  <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      sck   <= ~sck;
      rise  <= ~sck;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      rise  <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_clkgen.sv
// Master-mode I2S timing generator: SCK, WS, SCK-rise strobe and frame pulse.
// Divider, channel length and format are shadowed and only change at frame boundaries.
module i2s_clkgen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [1:0]           chl_i,
  input  logic [1:0]           fmt_i,
  output logic                 busy_o,
  output logic                 frame_o,
  output logic                 i2s_sck_o,
  output logic                 i2s_sck_trg_o,
  output logic                 i2s_ws_o
);

  import i2s_clkgen_pkg::*;

  i2s_clkgen_state_t    state_q, state_d;
  logic [DIV_WIDTH-1:0] div_sh, div_d;
  logic [1:0]           chl_sh, chl_d;
  logic [1:0]           fmt_sh, fmt_d;
  logic [5:0]           p_q, p_d;
  logic                 ws_q, ws_d;
  logic                 frame_q, frame_d;
  logic [5:0]           n_sh, n_new;
  logic                 running;
  logic                 sck;
  logic                 sck_rise;
  logic                 sck_fall;

  assign n_sh    = chl_to_n(chl_sh);
  assign n_new   = chl_to_n(chl_i);
  assign running = (state_q == I2S_CLKGEN_RUN);

  i2s_sck_div #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_sck_div (
    .clk  (clk_i),
    .rst  (rst_i),
    .run  (running),
    .div  (div_sh),
    .sck  (sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // Starting at p = 2N-1 makes the first SCK fall land on a frame boundary.
  always_comb begin
    state_d = state_q;
    div_d   = div_sh;
    chl_d   = chl_sh;
    fmt_d   = fmt_sh;
    p_d     = p_q;
    ws_d    = ws_q;
    frame_d = 1'b0;
    unique case (state_q)
      I2S_CLKGEN_IDLE: begin
        if (en_i) begin
          state_d = I2S_CLKGEN_RUN;
          div_d   = div_i;
          chl_d   = chl_i;
          fmt_d   = fmt_i;
          p_d     = last_bit(n_new);
          ws_d    = ws_for_bit(last_bit(n_new), n_new, fmt_i);
        end
      end
      I2S_CLKGEN_RUN: begin
        if (sck_fall) begin
          if (p_q == last_bit(n_sh)) begin
            p_d = 6'd0;
            if (en_i) begin
              frame_d = 1'b1;
              div_d   = div_i;
              chl_d   = chl_i;
              fmt_d   = fmt_i;
              ws_d    = ws_for_bit(6'd0, n_new, fmt_i);
            end else begin
              state_d = I2S_CLKGEN_IDLE;
              ws_d    = 1'b0;
            end
          end else begin
            p_d  = p_q + 6'd1;
            ws_d = ws_for_bit(p_q + 6'd1, n_sh, fmt_sh);
          end
        end
      end
      default: state_d = I2S_CLKGEN_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= I2S_CLKGEN_IDLE;
      div_sh  <= '0;
      chl_sh  <= '0;
      fmt_sh  <= '0;
      p_q     <= '0;
      ws_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_sh  <= div_d;
      chl_sh  <= chl_d;
      fmt_sh  <= fmt_d;
      p_q     <= p_d;
      ws_q    <= ws_d;
      frame_q <= frame_d;
    end
  end

  assign busy_o        = running;
  assign frame_o       = frame_q;
  assign i2s_sck_o     = sck;
  assign i2s_sck_trg_o = sck_rise;
  assign i2s_ws_o      = ws_q;

endmodule

// File: tb/tb_i2s_clkgen.sv
// Self-checking bench for i2s_clkgen: cycle-by-cycle compare against a frame-timeline
// model, plus directed latency/period/WS-position checks and a randomized run.
module tb_i2s_clkgen;

  import i2s_clkgen_pkg::*;

  logic        clk_i;
  logic        rst_i;
  logic        en_i;
  logic [15:0] div_i;
  logic [1:0]  chl_i;
  logic [1:0]  fmt_i;
  logic        busy_o;
  logic        frame_o;
  logic        i2s_sck_o;
  logic        i2s_sck_trg_o;
  logic        i2s_ws_o;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  i2s_clkgen #(.DIV_WIDTH(16)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .div_i         (div_i),
    .chl_i         (chl_i),
    .fmt_i         (fmt_i),
    .busy_o        (busy_o),
    .frame_o       (frame_o),
    .i2s_sck_o     (i2s_sck_o),
    .i2s_sck_trg_o (i2s_sck_trg_o),
    .i2s_ws_o      (i2s_ws_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic int n_of(input logic [1:0] chl);
    case (chl)
      2'd0:    return 8;
      2'd1:    return 16;
      2'd2:    return 24;
      default: return 32;
    endcase
  endfunction

  // Model: v counts clk cycles since the frame's p=0 fall; h = half-period, frame = 4*N*h.
  bit m_run  = 1'b0;
  bit chk_on = 1'b0;
  int m_v, m_h, m_n;
  bit m_lj;
  logic exp_busy, exp_sck, exp_trg, exp_ws, exp_frame;

  always @(posedge clk_i) begin
    int half, p;
    cyc++;
    if (rst_i) begin
      m_run  = 1'b0;
      chk_on = 1'b1;
    end else if (!m_run) begin
      if (en_i) begin
        m_run = 1'b1;
        m_h   = int'(div_i) + 1;
        m_n   = n_of(chl_i);
        m_lj  = (fmt_i != 2'b00);
        m_v   = 4 * m_n * m_h - 2 * m_h;
      end
    end else begin
      m_v++;
      if (m_v == 4 * m_n * m_h) begin
        if (en_i) begin
          m_h  = int'(div_i) + 1;
          m_n  = n_of(chl_i);
          m_lj = (fmt_i != 2'b00);
          m_v  = 0;
        end else begin
          m_run = 1'b0;
        end
      end
    end
    if (m_run) begin
      half      = m_v / m_h;
      p         = m_v / (2 * m_h);
      exp_busy  = 1'b1;
      exp_sck   = (half % 2) == 1;
      exp_trg   = ((m_v % m_h) == 0) && ((half % 2) == 1);
      exp_frame = (m_v == 0);
      exp_ws    = m_lj ? (p >= m_n) : ((p >= m_n - 1) && (p <= 2 * m_n - 2));
    end else begin
      exp_busy  = 1'b0;
      exp_sck   = 1'b0;
      exp_trg   = 1'b0;
      exp_frame = 1'b0;
      exp_ws    = 1'b0;
    end
  end

  logic [4:0] got_v, exp_v;
  always @(negedge clk_i) begin
    if (chk_on) begin
      got_v = {busy_o, i2s_sck_o, i2s_sck_trg_o, i2s_ws_o, frame_o};
      exp_v = {exp_busy, exp_sck, exp_trg, exp_ws, exp_frame};
      n_vec++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL cycle_check cycle %0d: busy,sck,trg,ws,frame got %b, expected %b",
                 cyc, got_v, exp_v);
      end
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_bad++;
    $display("[TB] FAIL %s: got timeout, expected event", name);
  endtask

  task automatic wait_frame(input int max, output int at, output int trgs);
    at   = -1;
    trgs = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_i);
      if (frame_o) begin
        at = cyc;
        break;
      end
      if (i2s_sck_trg_o) trgs++;
    end
    if (at < 0) fail_timeout("frame_wait");
  endtask

  task automatic wait_falls(input int n, input int max, output int trgs);
    int   falls;
    logic prev;
    falls = 0;
    trgs  = 0;
    prev  = i2s_sck_o;
    for (int i = 0; i < max && falls < n; i++) begin
      @(negedge clk_i);
      if (prev && !i2s_sck_o) falls++;
      prev = i2s_sck_o;
      if (i2s_sck_trg_o) trgs++;
    end
    if (falls < n) fail_timeout("fall_wait");
  endtask

  task automatic wait_idle(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_i);
      if (!busy_o) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) fail_timeout("idle_wait");
  endtask

  task automatic apply_stimulus(input logic en, input logic [15:0] div, input logic [1:0] chl,
                                input logic [1:0] fmt);
    en_i  = en;
    div_i = div;
    chl_i = chl;
    fmt_i = fmt;
  endtask

  initial begin
    int c0, f0, f1, f2, f3, s, t, tf;
    int falls, rise_at, fall_at;
    logic prev_sck, prev_ws;

    rst_i = 1'b1;
    apply_stimulus(1'b0, 16'd0, 2'd0, 2'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (20) @(negedge clk_i);
    check_output("idle_outputs", {busy_o, i2s_sck_o, i2s_sck_trg_o, i2s_ws_o, frame_o}, 0);

    // Left-justified, div=1, 8-bit: SCK period 4, frame every 64 clocks.
    apply_stimulus(1'b1, 16'd1, I2S_DAT_8_BITS, I2S_FMT_LJ);
    c0 = cyc;
    wait_frame(200, f0, t);
    check_output("lj_first_frame_latency", f0 - c0, 5);
    check_output("lj_trg_before_first_frame", t, 1);
    wait_frame(200, f1, t);
    check_output("lj_frame_period", f1 - f0, 64);
    check_output("lj_trg_per_frame", t, 16);
    en_i = 1'b0;
    wait_idle(200, s);

    // Philips I2S, div=0, 16-bit: WS high from the fall making p=15 to the one making p=31.
    apply_stimulus(1'b1, 16'd0, I2S_DAT_16_BITS, I2S_FMT_I2S);
    wait_frame(100, f0, t);
    falls    = 0;
    rise_at  = -1;
    fall_at  = -1;
    prev_sck = i2s_sck_o;
    prev_ws  = i2s_ws_o;
    for (int i = 0; i < 63; i++) begin
      @(negedge clk_i);
      if (prev_sck && !i2s_sck_o) falls++;
      if (!prev_ws && i2s_ws_o && rise_at < 0) rise_at = falls;
      if (prev_ws && !i2s_ws_o && fall_at < 0) fall_at = falls;
      prev_sck = i2s_sck_o;
      prev_ws  = i2s_ws_o;
    end
    check_output("i2s_ws_rise_bit", rise_at, 15);
    check_output("i2s_ws_fall_bit", fall_at, 31);
    en_i = 1'b0;
    wait_idle(200, s);

    // Reconfiguration at p=5 only takes effect at the next boundary.
    apply_stimulus(1'b1, 16'd3, I2S_DAT_8_BITS, I2S_FMT_LJ);
    wait_frame(400, f0, t);
    wait_falls(5, 200, tf);
    div_i = 16'd0;
    chl_i = I2S_DAT_32_BITS;
    wait_frame(400, f1, t);
    check_output("reconf_old_frame_len", f1 - f0, 128);
    check_output("reconf_old_frame_trgs", tf + t, 16);
    wait_frame(400, f2, t);
    check_output("reconf_new_frame_len", f2 - f1, 128);
    check_output("reconf_new_frame_trgs", t, 64);

    // Graceful stop: en dropped at p=3 of a 16-bit, div=1 frame.
    div_i = 16'd1;
    chl_i = I2S_DAT_16_BITS;
    wait_frame(400, f3, t);
    wait_falls(3, 200, tf);
    en_i = 1'b0;
    wait_idle(400, s);
    check_output("stop_at_boundary", s - f3, 128);
    check_output("stop_no_frame", frame_o, 0);

    // Reset at p=10 aborts at once; restart behaves like a fresh start.
    en_i = 1'b1;
    wait_frame(200, f0, t);
    wait_falls(10, 200, tf);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_output("reset_mid_frame", {busy_o, i2s_sck_o, i2s_sck_trg_o, i2s_ws_o, frame_o}, 0);
    rst_i = 1'b0;
    c0 = cyc;
    wait_frame(200, f1, t);
    check_output("restart_first_frame_latency", f1 - c0, 5);

    // Randomized run: settings, enable and occasional resets change at arbitrary cycles.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst_i = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk_i);
        rst_i = 1'b0;
      end
      apply_stimulus($urandom_range(0, 3) != 0, 16'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      for (int k = 0, len = $urandom_range(5, 400); k < len; k++) begin
        @(negedge clk_i);
        if ($urandom_range(0, 49) == 0) begin
          div_i = 16'($urandom_range(0, 3));
          chl_i = 2'($urandom_range(0, 3));
          fmt_i = 2'($urandom_range(0, 3));
        end
      end
    end
    en_i = 1'b0;
    wait_idle(2000, s);
    repeat (4) @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
